// File: rtl/input_port_pkg.sv
// Shared constants for the byte-wide input port and its FIFO.
package input_port_pkg;

  localparam int         IO_DEPTH      = 4;
  localparam logic [7:0] IO_EMPTY_BYTE = 8'h00;

  // Pointer index width; the FIFO adds one extra wrap bit on top.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Register-array FIFO with wrap-bit pointers; the caller guards push/pop against full/empty.
module io_fifo
  import input_port_pkg::*;
#(
  parameter int DEPTH = IO_DEPTH,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [ptr_w(DEPTH):0]  count
);

  localparam int AW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= din;
  end

  assign head  = mem_q[rptr_q[AW-1:0]];
  assign count = wptr_q - rptr_q;

endmodule

// File: rtl/input_port.sv
// Input port: valid/ready push into a small FIFO, c_gi drives the shared bus and pops.
module input_port
  import input_port_pkg::*;
#(
  parameter int DEPTH = IO_DEPTH,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       iport_data,
  input  logic                   iport_valid,
  output logic                   iport_ready,
  input  logic                   c_gi,
  inout  wire  [WIDTH-1:0]       data_bus,
  output logic                   in_empty,
  output logic [ptr_w(DEPTH):0]  in_count,
  output logic                   underflow
);

  localparam int CW = ptr_w(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;
  logic             underflow_q;
  logic             underflow_d;

  io_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (iport_data),
    .head  (head),
    .count (in_count)
  );

  // Status decodes from the registered count only, so ready never depends on c_gi.
  assign in_empty    = (in_count == '0);
  assign iport_ready = (in_count < CW'(DEPTH));

  assign push = iport_valid & iport_ready;
  assign pop  = c_gi & ~in_empty;

  assign underflow_d = underflow_q | (c_gi & in_empty);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) underflow_q <= 1'b0;
    else        underflow_q <= underflow_d;
  end

  assign underflow = underflow_q;

  assign data_bus = c_gi ? (in_empty ? WIDTH'(IO_EMPTY_BYTE) : head) : {WIDTH{1'bz}};

endmodule
